fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller for the instruction memory (combinational ROM, 40-bit words, PC-indexed).
//  - Drives the ROM address and registers the returned word into an instruction register (IR).
//  - Presents the IR to decode with a valid/ready handshake.
//  - Applies jump/call/return redirects from execute; call/return use a small return-address stack.
//  - Sits between the instruction memory and the decode/execute stages.
// PARAMETERS
//  INSTRUCTION_WIDTH  40  instruction word width (matches instruction memory)
//  PC_WIDTH           5   ROM address width; PC wraps modulo 2**PC_WIDTH
//  START_PC           0   PC loaded on start and on return-stack underflow
//  RS_DEPTH           4   return-stack entries (>=1)
// PORTS
//  clk             in   1                  clock, all state updates on rising edge
//  rst             in   1                  synchronous reset, active-high
//  start           in   1                  leave IDLE/HALT, begin fetching at START_PC
//  pc              out  PC_WIDTH           address to instruction memory
//  instruction     in   INSTRUCTION_WIDTH  word read from memory at pc (same cycle)
//  ir              out  INSTRUCTION_WIDTH  registered instruction to decode
//  ir_pc           out  PC_WIDTH           address ir was fetched from
//  ir_valid        out  1                  ir holds a valid instruction
//  ir_ready        in   1                  decode accepts ir this cycle
//  redir_valid     in   1                  redirect request from execute
//  redir_kind      in   2                  00 jump, 01 call, 10 return, 11 reserved (ignored)
//  redir_target    in   PC_WIDTH           jump/call destination
//  redir_link      in   PC_WIDTH           return address pushed on call
//  halt_req        in   1                  stop fetching
//  halted          out  1                  high while in HALT
//  stack_err       out  1                  sticky: return-stack overflow/underflow
// BEHAVIOUR
//  Reset: state=IDLE, pc=START_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, stack_err=0, stack empty.
//  FSM: IDLE -start-> FETCH; FETCH -halt_req-> HALT; HALT -start-> FETCH; any -rst-> IDLE.
//  - IDLE/HALT: pc held, ir_valid=0, redirects ignored.
//  - Entering FETCH: pc<=START_PC, stack cleared, stack_err kept.
//  FETCH, per cycle, priority highest first:
//  1. halt_req: ir_valid<=0, state<=HALT, halted<=1 next cycle. An in-flight ir handshake completing this cycle still counts.
//  2. redir_valid (kind!=11): ir_valid<=0 (flush), pc<=dest, no capture.
//     - jump: dest=redir_target.
//     - call: dest=redir_target; push redir_link. If stack full: push dropped, stack_err<=1, jump still taken.
//     - return: dest=top of stack, pop. If stack empty: dest=START_PC, stack_err<=1.
//  3. Capture when !ir_valid or ir_ready: ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (wraps 2**PC_WIDTH-1 -> 0).
//  4. Otherwise (ir_valid && !ir_ready): pc, ir, ir_pc held stable.
//  Handshake: transfer when ir_valid&&ir_ready. ir/ir_pc must not change while ir_valid&&!ir_ready, except for a flush.
//  Latency: start at edge N -> pc=START_PC after N -> ir_valid=1 after N+1. Redirect at edge N -> ir valid at N+2.
//  Throughput: one instruction/cycle with ir_ready held high.
//  Reset mid-operation: rst overrides everything next edge; no partial state survives.
// CONFIGURATION
//  CALL_STACK_EN defined: return stack and call/return as above.
//  CALL_STACK_EN undefined:
//  - no stack storage; call behaves as jump (link ignored).
//  - return is ignored (treated as no redirect).
//  - stack_err tied to 0.
// TESTING
//  1. rst, start pulse, ir_ready=1, ROM[i]=i -> pc 0,1,2..; ir=ROM[k] with ir_pc=k one cycle after pc=k; wrap 31->0.
//  2. ir_ready=0 for 3 cycles at ir_pc=5 -> ir,ir_pc,pc frozen (ir_pc=5, pc=6); release -> ir_pc=6 next cycle.
//  3. jump redir_target=20 while ir_valid=1 -> ir_valid=0 next cycle, pc=20, ir_pc=20 valid following cycle.
//  4. call (target=10, link=3), then return -> pc=10 then pc=3.
//     - RS_DEPTH+1 calls -> stack_err=1, last push dropped.
//     - return on empty stack -> pc=START_PC, stack_err=1.
//  5. halt_req with redir_valid same cycle -> HALT, halted=1, pc unchanged; start -> pc=START_PC, stack empty.
//  6. rst asserted during stalled FETCH -> all outputs at reset values next cycle, state IDLE until start.
//  - Run 4 both with and without CALL_STACK_EN (without: return no-op, stack_err=0).

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a combinational, PC-indexed ROM.
// It drives pc, registers the returned word into ir/ir_pc and offers it to decode
// over a valid/ready handshake. Jump/call/return redirects from execute flush ir.
// Optional feature macro: CALL_STACK_EN. When it is defined, a return-address stack
// is built and call/return use it. When it is undefined, call acts as a jump, return
// is ignored and stack_err is tied low.
module fetch_sequencer #(
    parameter int INSTRUCTION_WIDTH = 40,
    parameter int PC_WIDTH          = 5,
    parameter int START_PC          = 0,
    parameter int RS_DEPTH          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic                         ir_valid,
    input  logic                         ir_ready,
    input  logic                         redir_valid,
    input  logic [1:0]                   redir_kind,
    input  logic [PC_WIDTH-1:0]          redir_target,
    input  logic [PC_WIDTH-1:0]          redir_link,
    input  logic                         halt_req,
    output logic                         halted,
    output logic                         stack_err
);

    localparam logic [PC_WIDTH-1:0] START_ADDR = PC_WIDTH'(START_PC);

    localparam logic [1:0] KIND_JUMP   = 2'b00;
    localparam logic [1:0] KIND_CALL   = 2'b01;
    localparam logic [1:0] KIND_RETURN = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                         state_reg, state_next;
    logic [PC_WIDTH-1:0]            pc_reg, pc_next;
    logic [INSTRUCTION_WIDTH-1:0]   ir_reg, ir_next;
    logic [PC_WIDTH-1:0]            ir_pc_reg, ir_pc_next;
    logic                           ir_valid_reg, ir_valid_next;

`ifdef CALL_STACK_EN
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [PC_WIDTH-1:0] rs_mem [RS_DEPTH];
    logic [CW-1:0]       rs_count_reg, rs_count_next;
    logic                err_reg, err_next;
    logic                push_en;
    logic                rs_full;
    logic                rs_empty;
    logic [IW-1:0]       top_idx;
    logic [IW-1:0]       push_idx;

    assign rs_full  = (rs_count_reg == CW'(RS_DEPTH));
    assign rs_empty = (rs_count_reg == '0);
    assign top_idx  = IW'(rs_count_reg - CW'(1));
    assign push_idx = IW'(rs_count_reg);
`else
    // Link address and stack depth have no consumer when the stack is not built.
    logic                unused_link;
    logic [RS_DEPTH-1:0] unused_depth;
    assign unused_link  = ^redir_link;
    assign unused_depth = '0;
`endif

    // Next-state and datapath selection; priority halt > redirect > capture > hold.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
`ifdef CALL_STACK_EN
        rs_count_next = rs_count_reg;
        err_next      = err_reg;
        push_en       = 1'b0;
`endif
        case (state_reg)
            IDLE, HALT: begin
                ir_valid_next = 1'b0;
                if (start) begin
                    state_next = FETCH;
                    pc_next    = START_ADDR;
`ifdef CALL_STACK_EN
                    rs_count_next = '0;
`endif
                end
            end
            FETCH: begin
                if (halt_req) begin
                    ir_valid_next = 1'b0;
                    state_next    = HALT;
                end else if (redir_valid && redir_kind == KIND_JUMP) begin
                    ir_valid_next = 1'b0;
                    pc_next       = redir_target;
                end else if (redir_valid && redir_kind == KIND_CALL) begin
                    ir_valid_next = 1'b0;
                    pc_next       = redir_target;
`ifdef CALL_STACK_EN
                    if (rs_full) begin
                        err_next = 1'b1;
                    end else begin
                        push_en       = 1'b1;
                        rs_count_next = rs_count_reg + CW'(1);
                    end
`endif
                end
`ifdef CALL_STACK_EN
                else if (redir_valid && redir_kind == KIND_RETURN) begin
                    ir_valid_next = 1'b0;
                    if (rs_empty) begin
                        pc_next  = START_ADDR;
                        err_next = 1'b1;
                    end else begin
                        pc_next       = rs_mem[top_idx];
                        rs_count_next = rs_count_reg - CW'(1);
                    end
                end
`endif
                else if (!ir_valid_reg || ir_ready) begin
                    ir_next       = instruction;
                    ir_pc_next    = pc_reg;
                    ir_valid_next = 1'b1;
                    pc_next       = pc_reg + PC_WIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fetch state and instruction register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= START_ADDR;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
        end
    end

`ifdef CALL_STACK_EN
    // Return-stack occupancy and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_count_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            rs_count_reg <= rs_count_next;
            err_reg      <= err_next;
        end
    end

    // Return-stack storage; entries need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_en) begin
            rs_mem[push_idx] <= redir_link;
        end
    end

    assign stack_err = err_reg;
`else
    assign stack_err = 1'b0;
`endif

    assign pc       = pc_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign halted   = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed phases followed by random traffic, checked against a
// queue-based behavioural model. Handshake transfers go through a scoreboard queue
// that a negedge monitor drains; visible outputs are compared every cycle.
module tb_fetch_sequencer;

    localparam int IW    = 40;
    localparam int PW    = 5;
    localparam int START = 0;
    localparam int DEPTH = 4;
    localparam int NROM  = 32;

    logic          clk = 1'b0;
    logic          rst, start, ir_ready, redir_valid, halt_req;
    logic [1:0]    redir_kind;
    logic [PW-1:0] redir_target, redir_link;
    logic [PW-1:0] pc, ir_pc;
    logic [IW-1:0] instruction, ir;
    logic          ir_valid, halted, stack_err;

    logic [IW-1:0] rom [NROM];
    assign instruction = rom[pc];

    fetch_sequencer #(
        .INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .START_PC(START), .RS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .instruction(instruction),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_target(redir_target),
        .redir_link(redir_link), .halt_req(halt_req), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    // Behavioural model: 0 idle, 1 fetching, 2 halted.
    int            m_state = 0;
    int            m_pc    = 0;
    bit            m_valid = 1'b0;
    logic [IW-1:0] m_ir    = '0;
    int            m_irpc  = 0;
    bit            m_err   = 1'b0;
    int            m_stack [$];

    logic [PW+IW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        // A handshake in this cycle completes even if halt, flush or reset follows.
        if (m_valid && ir_ready) exp_q.push_back({PW'(m_irpc), m_ir});
        if (rst) begin
            m_state = 0; m_pc = START; m_valid = 0; m_ir = '0; m_irpc = 0; m_err = 0;
            m_stack.delete();
        end else if (m_state != 1) begin
            m_valid = 0;
            if (start) begin
                m_state = 1; m_pc = START; m_stack.delete();
            end
        end else if (halt_req) begin
            m_valid = 0; m_state = 2;
        end else if (redir_valid && redir_kind == 2'd0) begin
            m_valid = 0; m_pc = int'(redir_target);
        end else if (redir_valid && redir_kind == 2'd1) begin
            m_valid = 0; m_pc = int'(redir_target);
`ifdef CALL_STACK_EN
            if (m_stack.size() == DEPTH) m_err = 1;
            else m_stack.push_back(int'(redir_link));
`endif
        end
`ifdef CALL_STACK_EN
        else if (redir_valid && redir_kind == 2'd2) begin
            m_valid = 0;
            if (m_stack.size() == 0) begin
                m_pc = START; m_err = 1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end
`endif
        else if (!m_valid || ir_ready) begin
            m_ir = rom[m_pc]; m_irpc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % NROM;
        end
    endtask

    task automatic check_outputs();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("ir_valid", 64'(ir_valid), 64'(m_valid));
        chk("ir_pc", 64'(ir_pc), 64'(m_irpc));
        chk("ir", 64'(ir), 64'(m_ir));
        chk("halted", 64'(halted), 64'(m_state == 2));
        chk("stack_err", 64'(stack_err), 64'(m_err));
    endtask

    task automatic drive(input bit r, input bit s, input bit rdy, input bit rv,
                         input bit [1:0] k, input int tgt, input int lnk, input bit h);
        rst = r; start = s; ir_ready = rdy; redir_valid = rv; redir_kind = k;
        redir_target = PW'(tgt); redir_link = PW'(lnk); halt_req = h;
        model_step();
    endtask

    task automatic cyc(input bit r, input bit s, input bit rdy, input bit rv,
                       input bit [1:0] k, input int tgt, input int lnk, input bit h);
        @(posedge clk); #1;
        check_outputs();
        mon_en = 1'b1;
        drive(r, s, rdy, rv, k, tgt, lnk, h);
    endtask

    task automatic idle_n(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, rdy, 0, 2'd0, 0, 0, 0);
    endtask

    // Monitor: each accepted ir must match the oldest expected transfer.
    always @(negedge clk) begin
        if (mon_en && ir_valid === 1'b1 && ir_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 64'({ir_pc, ir}), 64'd0);
            end else begin
                logic [PW+IW-1:0] e;
                e = exp_q.pop_front();
                chk("xfer", 64'({ir_pc, ir}), 64'(e));
                $display("xfer ir_pc=%0d ir=%h", ir_pc, ir);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NROM; i++) rom[i] = {8'(i), 32'($urandom)};
        drive(1, 0, 1, 0, 2'd0, 0, 0, 0);

        // Reset, start, free-running fetch across the pc wrap.
        cyc(1, 0, 1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2'd0, 0, 0, 0);
        idle_n(40, 1);

        // Restart and stall decode around ir_pc=5.
        cyc(1, 0, 1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2'd0, 0, 0, 0);
        idle_n(6, 1);
        idle_n(3, 0);
        idle_n(3, 1);

        // Jump while ir is valid.
        cyc(0, 0, 1, 1, 2'd0, 20, 0, 0);
        idle_n(3, 1);

        // Call then return, overflow the stack, then drain into underflow.
        cyc(0, 0, 1, 1, 2'd1, 10, 3, 0);
        idle_n(2, 1);
        cyc(0, 0, 1, 1, 2'd2, 0, 0, 0);
        idle_n(2, 1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(0, 0, 1, 1, 2'd1, 8 + i, 16 + i, 0);
            idle_n(1, 1);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(0, 0, 1, 1, 2'd2, 0, 0, 0);
            idle_n(1, 1);
        end
        cyc(0, 0, 1, 1, 2'd3, 7, 7, 0);
        idle_n(2, 1);

        // Halt together with a redirect, sit halted, restart.
        cyc(0, 0, 1, 1, 2'd0, 25, 0, 1);
        idle_n(3, 1);
        cyc(0, 0, 1, 1, 2'd0, 12, 0, 0);
        cyc(0, 1, 1, 0, 2'd0, 0, 0, 0);
        idle_n(3, 1);

        // Reset during a stall, stay idle, restart.
        idle_n(2, 0);
        cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
        idle_n(3, 1);
        cyc(0, 1, 1, 0, 2'd0, 0, 0, 0);
        idle_n(3, 1);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 49) == 0);
        end

        @(posedge clk); #1;
        check_outputs();
        drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
